nbody_host_port: RTL and testbench
==================================

# nbody_host_port

Parametrised host-side front end for the n-body accelerator. It sits between the 64-bit memory-mapped slave bus and the compute core plus its per-field state memories. It provides:
- assembly of 64-bit doubles from 32-bit half writes, for any number of body fields;
- control and status registers;
- a run FSM that steps the core and automatically freezes it every GAP steps, so the host can read a consistent frame;
- registered readback.

## Interface
- `BODY_AW`, 9: body index width; max bodies 2^BODY_AW.
- `ADDR_W`, 16: bus address width; select code is `addr[ADDR_W-1:BODY_AW]`, 7 bits at default.
- `NUM_FIELDS`, 5: number of per-body 64-bit fields, 1..16. Default fields are 0=X, 1=Y, 2=M, 3=VX, 4=VY.
- `STEP_W`, 32: width of the step counter and of the GAP register.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `chipselect`, `read`, `write` in 1 each: bus strobes.
- `addr` in ADDR_W: `{sel, body_idx}`.
- `writedata` in 64: bus write data; for half writes only [31:0] is used.
- `readdata` out 64: registered read data.
- `n_bodies` out BODY_AW+1: body count for the core.
- `step_start` out 1: one-cycle pulse that starts one core timestep.
- `step_done` in 1: one-cycle pulse from the core when the step completes.
- `freeze` out 1: while high, the core must not touch the state memories; the host owns them.
- `mem_wr_en` out 1, `mem_wr_field` out 4, `mem_wr_idx` out BODY_AW, `mem_wr_data` out 64: state-memory write port.
- `mem_rd_en` out 1, `mem_rd_field` out 4, `mem_rd_idx` out BODY_AW: state-memory read request.
- `mem_rd_data` in 64: read data, returned 1 cycle after `mem_rd_en`.

## Operation
Select map:
- 0x00 GO (bit0)
- 0x01 READ (bit0; hold request)
- 0x02 N_BODIES
- 0x03 GAP
- 0x04 STATUS (read-only): bit0 done, bit1 hold, bit2 running, bit3 wr_err, bit4 rd_err, [63:32] total step count
- 0x10+2f+h: field f write. h=0 is the lower half; h=1 is the upper half.
- 0x40+2f+h: field f read, returning the selected half zero-extended.
- Unmapped selects, or f ≥ NUM_FIELDS: writes are ignored and reads return 0.
- A bus access is valid only when `chipselect` is high. If `write` and `read` are both high, the write is performed and the read is ignored.

Field writes:
- A lower-half write stores `writedata[31:0]` in `stage[f]`.
- An upper-half write commits `{writedata[31:0], stage[f]}` to (f, body_idx).
- Registers 0x00–0x03 are readable at their own selects.

FSM states: IDLE, START, WAIT, HOLD.
- IDLE (freeze=1): moves to START when GO=1 and N_BODIES≠0.
- START (freeze=0): `step_start`=1 for one cycle, then → WAIT.
- WAIT (freeze=0): on `step_done`, increment the step counters and then:
  - GO=0 → IDLE;
  - else gap counter reaches GAP, or READ=1 → HOLD; reaching GAP also sets done and clears the gap counter;
  - else → START.
- HOLD (freeze=1):
  - exit requires that READ=1 has been written and then READ=0 has been written;
  - on that exit, done is cleared; then → START if GO=1, else → IDLE;
  - writing GO=0 while in HOLD → IDLE immediately; done is kept.
- GAP=0 is treated as 1.
- A field read or field write outside IDLE/HOLD is dropped and sets rd_err/wr_err. Both are sticky and are cleared by writing STATUS.
- `step_done` in any state other than WAIT is ignored.

## Timing
- Reset values: every output is 0 except `freeze`=1. All registers, staging halves, counters and errors are 0; the FSM is in IDLE.
- Reset mid-step discards the step. A `step_done` arriving after reset is ignored.
- Register and STATUS reads: `readdata` is valid at the 1st clock edge after the strobe.
- Field reads: `mem_rd_*` is driven combinationally in the strobe cycle. `readdata` is valid at the 2nd edge after the strobe.
- `readdata` holds its value until the next accepted read.
- Upper-half commit: `mem_wr_en` pulses for one cycle, one cycle after the strobe.
- GO=1 written in IDLE → `step_start` 2 cycles later.
- `step_done` → next `step_start` 1 cycle later, when the FSM does not go to HOLD.

## Structure
- Package `nbody_pkg` holds the select-code constants, the STATUS bit positions, the FSM state enum and the field-index constants.
- Submodule `nbody_half_stager` holds the NUM_FIELDS×32 staging array and the commit logic. The FSM and register file stay in the top level.

## Test plan
- Reset mid-run: assert `rst` low during WAIT → `freeze`=1, `readdata`=0, STATUS=0, and no `step_start` until GO is rewritten.
- Double assembly: write field 0, body 3, lower half 0x00000000, then upper half 0x3FF00000 → one `mem_wr_en` pulse with idx 3 and data 0x3FF0000000000000 (1.0); no write on the lower half.
- Automatic hold: N_BODIES=25, GAP=6, GO=1, core model with 122-cycle steps → exactly 6 `step_start` pulses, then `freeze`=1, done=1, step count=6.
- Readback: in HOLD, read 0x40/0x41, body 2 → mocked halves valid at the 2nd edge after each strobe. Then write READ=1 followed by READ=0 → done cleared and `step_start` the next cycle.
- Field write during WAIT → no `mem_wr_en` and wr_err=1; writing STATUS clears it.
- `step_done` in the same cycle that GO=0 is written → step counted, FSM in IDLE, no further `step_start`.

Source files
------------

// File: rtl/nbody_pkg.sv
// Shared constants for the n-body host port: bus select map, STATUS layout,
// run-FSM states and default field indices.
package nbody_pkg;

  localparam int unsigned SelGo      = 'h00;
  localparam int unsigned SelRead    = 'h01;
  localparam int unsigned SelNBodies = 'h02;
  localparam int unsigned SelGap     = 'h03;
  localparam int unsigned SelStatus  = 'h04;
  localparam int unsigned SelFieldWr = 'h10;
  localparam int unsigned SelFieldRd = 'h40;

  localparam int unsigned StatDone    = 0;
  localparam int unsigned StatHold    = 1;
  localparam int unsigned StatRunning = 2;
  localparam int unsigned StatWrErr   = 3;
  localparam int unsigned StatRdErr   = 4;
  localparam int unsigned StatStepLsb = 32;

  localparam int unsigned FieldX  = 0;
  localparam int unsigned FieldY  = 1;
  localparam int unsigned FieldM  = 2;
  localparam int unsigned FieldVx = 3;
  localparam int unsigned FieldVy = 4;

  typedef enum logic [1:0] {StIdle, StStart, StWait, StHold} state_e;

  // Field windows hold two selects (lower, upper half) per field.
  function automatic logic in_field_window(input int unsigned sel, input int unsigned base,
                                           input int unsigned num_fields);
    return (sel >= base) && (sel < base + (num_fields << 1));
  endfunction

endpackage

// File: rtl/nbody_host_port_if.sv
// Memory-mapped 64-bit slave bus between the host and the n-body host port.
interface nbody_host_port_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              chipselect;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       writedata;
  logic [63:0]       readdata;

  modport master (output chipselect, read, write, addr, writedata, input readdata);
  modport slave  (input chipselect, read, write, addr, writedata, output readdata);
endinterface

// File: rtl/nbody_half_stager.sv
// Per-field staging of lower 32-bit halves; an upper-half write commits the full
// 64-bit double to the state memory one cycle later.
module nbody_half_stager #(
  parameter int unsigned BODY_AW    = 9,
  parameter int unsigned NUM_FIELDS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_lo,
  input  logic               wr_hi,
  input  logic [3:0]         field,
  input  logic [BODY_AW-1:0] idx,
  input  logic [31:0]        data,
  output logic               mem_wr_en,
  output logic [3:0]         mem_wr_field,
  output logic [BODY_AW-1:0] mem_wr_idx,
  output logic [63:0]        mem_wr_data
);

  logic [31:0] stage_q [NUM_FIELDS];
  logic [31:0] stage_sel;

  always_comb begin
    stage_sel = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (field == 4'(i)) stage_sel = stage_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FIELDS; i++) stage_q[i] <= '0;
      mem_wr_en    <= 1'b0;
      mem_wr_field <= '0;
      mem_wr_idx   <= '0;
      mem_wr_data  <= '0;
    end else begin
      mem_wr_en <= wr_hi;
      for (int i = 0; i < NUM_FIELDS; i++) begin
        if (wr_lo && field == 4'(i)) stage_q[i] <= data;
      end
      if (wr_hi) begin
        mem_wr_field <= field;
        mem_wr_idx   <= idx;
        mem_wr_data  <= {data, stage_sel};
      end
    end
  end

endmodule

// File: rtl/nbody_host_port.sv
// Host-side front end of the n-body accelerator: control/status registers, run FSM
// with periodic freeze, 64-bit write assembly and registered readback.
module nbody_host_port
  import nbody_pkg::*;
#(
  parameter int unsigned BODY_AW    = 9,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned NUM_FIELDS = 5,
  parameter int unsigned STEP_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  nbody_host_port_if.slave   bus,
  output logic [BODY_AW:0]   n_bodies,
  output logic               step_start,
  input  logic               step_done,
  output logic               freeze,
  output logic               mem_wr_en,
  output logic [3:0]         mem_wr_field,
  output logic [BODY_AW-1:0] mem_wr_idx,
  output logic [63:0]        mem_wr_data,
  output logic               mem_rd_en,
  output logic [3:0]         mem_rd_field,
  output logic [BODY_AW-1:0] mem_rd_idx,
  input  logic [63:0]        mem_rd_data
);

  localparam int unsigned SelW = ADDR_W - BODY_AW;

  state_e             state_q, state_d;
  logic               go_q, read_q, done_q, wr_err_q, rd_err_q;
  logic [BODY_AW:0]   nb_q;
  logic [STEP_W-1:0]  gap_q, step_cnt_q, gap_cnt_q;
  logic [63:0]        readdata_q, reg_rdata;
  logic               rd_pend_q, rd_half_q;

  logic [SelW-1:0]    sel;
  logic [31:0]        sel32;
  logic [BODY_AW-1:0] body_idx;
  logic               wr_acc, rd_acc, host_owns;
  logic               fwr_hit, frd_hit, fwr_ok, frd_ok, f_half;
  logic [3:0]         f_field;
  logic               wr_go, wr_read, wr_nb, wr_gap, wr_status;
  logic               go_eff, read_eff, hold_release;
  logic [STEP_W-1:0]  gap_eff, gap_next;
  logic               step_inc, gap_clr, done_set, done_clr;
  logic               unused_wdata;

  assign sel       = bus.addr[ADDR_W-1:BODY_AW];
  assign body_idx  = bus.addr[BODY_AW-1:0];
  assign sel32     = 32'(sel);
  assign wr_acc    = bus.chipselect & bus.write;
  assign rd_acc    = bus.chipselect & bus.read & ~bus.write;
  assign host_owns = (state_q == StIdle) || (state_q == StHold);

  assign fwr_hit = in_field_window(sel32, SelFieldWr, NUM_FIELDS);
  assign frd_hit = in_field_window(sel32, SelFieldRd, NUM_FIELDS);
  assign fwr_ok  = wr_acc & fwr_hit & host_owns;
  assign frd_ok  = rd_acc & frd_hit & host_owns;
  // Both windows start on an even select: bit0 is the half, the rest is the field.
  assign f_half  = sel[0];
  assign f_field = fwr_hit ? 4'((sel32 - SelFieldWr) >> 1) : 4'((sel32 - SelFieldRd) >> 1);

  assign wr_go     = wr_acc && (sel32 == SelGo);
  assign wr_read   = wr_acc && (sel32 == SelRead);
  assign wr_nb     = wr_acc && (sel32 == SelNBodies);
  assign wr_gap    = wr_acc && (sel32 == SelGap);
  assign wr_status = wr_acc && (sel32 == SelStatus);

  // A register write in the same cycle as step_done takes effect for that decision.
  assign go_eff       = wr_go ? bus.writedata[0] : go_q;
  assign read_eff     = wr_read ? bus.writedata[0] : read_q;
  assign hold_release = (state_q == StHold) && wr_read && !bus.writedata[0] && read_q;
  assign gap_eff      = (gap_q == '0) ? STEP_W'(1) : gap_q;
  assign gap_next     = gap_cnt_q + STEP_W'(1);

  always_comb begin
    state_d  = state_q;
    step_inc = 1'b0;
    gap_clr  = 1'b0;
    done_set = 1'b0;
    done_clr = 1'b0;
    unique case (state_q)
      StIdle:  if (go_q && nb_q != '0) state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        if (step_done) begin
          step_inc = 1'b1;
          if (!go_eff) begin
            state_d = StIdle;
          end else if (gap_next >= gap_eff) begin
            state_d  = StHold;
            done_set = 1'b1;
            gap_clr  = 1'b1;
          end else if (read_eff) begin
            state_d = StHold;
          end else begin
            state_d = StStart;
          end
        end
      end
      StHold: begin
        if (wr_go && !bus.writedata[0]) begin
          state_d = StIdle;
        end else if (hold_release) begin
          done_clr = 1'b1;
          state_d  = go_eff ? StStart : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    reg_rdata = '0;
    case (sel32)
      SelGo:      reg_rdata[0] = go_q;
      SelRead:    reg_rdata[0] = read_q;
      SelNBodies: reg_rdata[BODY_AW:0] = nb_q;
      SelGap:     reg_rdata[STEP_W-1:0] = gap_q;
      SelStatus: begin
        reg_rdata[StatDone]          = done_q;
        reg_rdata[StatHold]          = (state_q == StHold);
        reg_rdata[StatRunning]       = (state_q == StStart) || (state_q == StWait);
        reg_rdata[StatWrErr]         = wr_err_q;
        reg_rdata[StatRdErr]         = rd_err_q;
        reg_rdata[StatStepLsb +: 32] = 32'(step_cnt_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      go_q       <= 1'b0;
      read_q     <= 1'b0;
      nb_q       <= '0;
      gap_q      <= '0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      step_cnt_q <= '0;
      gap_cnt_q  <= '0;
      readdata_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_half_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_go)   go_q   <= bus.writedata[0];
      if (wr_read) read_q <= bus.writedata[0];
      if (wr_nb)   nb_q   <= bus.writedata[BODY_AW:0];
      if (wr_gap)  gap_q  <= bus.writedata[STEP_W-1:0];
      if (step_inc) begin
        step_cnt_q <= step_cnt_q + STEP_W'(1);
        gap_cnt_q  <= gap_clr ? '0 : gap_next;
      end
      if (done_set)      done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;
      if (wr_status) begin
        wr_err_q <= 1'b0;
        rd_err_q <= 1'b0;
      end else begin
        if (wr_acc && fwr_hit && !host_owns) wr_err_q <= 1'b1;
        if (rd_acc && frd_hit && !host_owns) rd_err_q <= 1'b1;
      end
      rd_pend_q <= frd_ok;
      rd_half_q <= f_half;
      if (rd_pend_q) begin
        readdata_q <= rd_half_q ? {32'h0, mem_rd_data[63:32]} : {32'h0, mem_rd_data[31:0]};
      end else if (rd_acc && !frd_hit) begin
        readdata_q <= reg_rdata;
      end
    end
  end

  nbody_half_stager #(
    .BODY_AW    (BODY_AW),
    .NUM_FIELDS (NUM_FIELDS)
  ) u_stager (
    .clk          (clk),
    .rst          (rst),
    .wr_lo        (fwr_ok & ~f_half),
    .wr_hi        (fwr_ok & f_half),
    .field        (f_field),
    .idx          (body_idx),
    .data         (bus.writedata[31:0]),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_field (mem_wr_field),
    .mem_wr_idx   (mem_wr_idx),
    .mem_wr_data  (mem_wr_data)
  );

  assign mem_rd_en    = frd_ok;
  assign mem_rd_field = frd_ok ? f_field : '0;
  assign mem_rd_idx   = frd_ok ? body_idx : '0;

  assign bus.readdata = readdata_q;
  assign n_bodies     = nb_q;
  assign step_start   = (state_q == StStart);
  assign freeze       = host_owns;
  assign unused_wdata = ^bus.writedata;

endmodule

// File: tb/tb_nbody_host_port.sv
// Directed bench for nbody_host_port: register map, double assembly, auto hold,
// readback, access errors, reset mid-run and GO/step_done interplay.
module tb_nbody_host_port;

  localparam int unsigned SGo = 'h00, SRead = 'h01, SNb = 'h02, SGap = 'h03, SStat = 'h04;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  n_bodies;
  logic        step_start, step_done, freeze;
  logic        mem_wr_en, mem_rd_en;
  logic [3:0]  mem_wr_field, mem_rd_field;
  logic [8:0]  mem_wr_idx, mem_rd_idx;
  logic [63:0] mem_wr_data, mem_rd_data;

  logic        core_auto = 1'b0;
  logic        core_done = 1'b0;
  logic        tb_done = 1'b0;
  int          core_cnt = 0;
  int          starts = 0;
  int          wr_pulses = 0;
  int          checks = 0;
  int          errors = 0;

  nbody_host_port_if #(.ADDR_W(16)) bif ();

  nbody_host_port #(
    .BODY_AW(9), .ADDR_W(16), .NUM_FIELDS(5), .STEP_W(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bif),
    .n_bodies     (n_bodies),
    .step_start   (step_start),
    .step_done    (step_done),
    .freeze       (freeze),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_field (mem_wr_field),
    .mem_wr_idx   (mem_wr_idx),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_field (mem_rd_field),
    .mem_rd_idx   (mem_rd_idx),
    .mem_rd_data  (mem_rd_data)
  );

  always #5 clk = ~clk;

  assign step_done = core_done | tb_done;

  // Core model: step_done 122 cycles after each step_start; ignores reset on purpose.
  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_auto && step_start) begin
      core_cnt <= 122;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) core_done <= 1'b1;
    end
  end

  // Mocked state memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= {32'hC0DE_0000 + 32'(mem_rd_idx),
                      32'h1234_0000 + (32'(mem_rd_field) << 8) + 32'(mem_rd_idx)};
    end
  end

  always @(posedge clk) begin
    if (step_start) starts <= starts + 1;
    if (mem_wr_en) wr_pulses <= wr_pulses + 1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input int unsigned sel, input int unsigned idx, input logic [63:0] d);
    bif.chipselect = 1'b1;
    bif.write      = 1'b1;
    bif.addr       = 16'((sel << 9) | idx);
    bif.writedata  = d;
    tick(1);
    bif.chipselect = 1'b0;
    bif.write      = 1'b0;
  endtask

  task automatic reg_rd(input int unsigned sel, output logic [63:0] d);
    bif.chipselect = 1'b1;
    bif.read       = 1'b1;
    bif.addr       = 16'(sel << 9);
    tick(1);
    bif.chipselect = 1'b0;
    bif.read       = 1'b0;
    d = bif.readdata;
  endtask

  task automatic fld_rd(input int unsigned sel, input int unsigned idx, output logic en,
                        output logic [3:0] fld, output logic [8:0] ix, output logic [63:0] d);
    bif.chipselect = 1'b1;
    bif.read       = 1'b1;
    bif.addr       = 16'((sel << 9) | idx);
    #1;
    en  = mem_rd_en;
    fld = mem_rd_field;
    ix  = mem_rd_idx;
    tick(1);
    bif.chipselect = 1'b0;
    bif.read       = 1'b0;
    tick(1);
    d = bif.readdata;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [63:0] d;
    logic        en;
    logic [3:0]  fld;
    logic [8:0]  ix;
    int          base;
    logic        hit;

    bif.chipselect = 1'b0;
    bif.read       = 1'b0;
    bif.write      = 1'b0;
    bif.addr       = '0;
    bif.writedata  = '0;
    tick(3);
    rst = 1'b1;
    tick(1);

    // Reset state
    check("rst_freeze", 64'(freeze), 64'd1);
    check("rst_step_start", 64'(step_start), 64'd0);
    check("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
    check("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
    check("rst_readdata", bif.readdata, 64'd0);
    check("rst_n_bodies", 64'(n_bodies), 64'd0);
    reg_rd(SStat, d);
    check("rst_status", d, 64'd0);

    // GO with N_BODIES=0 must not start
    base = starts;
    bus_wr(SGo, 0, 64'd1);
    tick(4);
    check("go_nb0_starts", 64'(starts - base), 64'd0);
    check("go_nb0_freeze", 64'(freeze), 64'd1);
    reg_rd(SGo, d);
    check("rd_go", d, 64'd1);
    bus_wr(SGo, 0, 64'd0);

    // Double assembly
    base = wr_pulses;
    bus_wr('h10, 3, 64'h0);
    check("lo_no_commit", 64'(mem_wr_en), 64'd0);
    bus_wr('h11, 3, 64'h3FF0_0000);
    check("hi_commit_en", 64'(mem_wr_en), 64'd1);
    check("hi_commit_idx", 64'(mem_wr_idx), 64'd3);
    check("hi_commit_field", 64'(mem_wr_field), 64'd0);
    check("hi_commit_data", mem_wr_data, 64'h3FF0_0000_0000_0000);
    tick(1);
    check("commit_one_cycle", 64'(mem_wr_en), 64'd0);
    bus_wr('h18, 'h1FF, 64'hFFFF_FFFF_DEAD_BEEF);
    bus_wr('h19, 'h1FF, 64'hAAAA_AAAA_1234_5678);
    check("vy_commit_field", 64'(mem_wr_field), 64'd4);
    check("vy_commit_idx", 64'(mem_wr_idx), 64'h1FF);
    check("vy_commit_data", mem_wr_data, 64'h1234_5678_DEAD_BEEF);
    bus_wr('h1B, 7, 64'h5555);
    check("unmapped_field_wr", 64'(mem_wr_en), 64'd0);
    tick(1);
    check("commit_pulses", 64'(wr_pulses - base), 64'd2);

    // Register readback and unmapped read
    bus_wr(SNb, 0, 64'd25);
    bus_wr(SGap, 0, 64'd6);
    reg_rd(SNb, d);
    check("rd_n_bodies", d, 64'd25);
    check("n_bodies_port", 64'(n_bodies), 64'd25);
    reg_rd(SGap, d);
    check("rd_gap", d, 64'd6);
    reg_rd('h05, d);
    check("rd_unmapped", d, 64'd0);
    reg_rd(SStat, d);
    check("status_idle", d, 64'd0);

    // Automatic hold after GAP steps
    core_auto = 1'b1;
    base = starts;
    bus_wr(SGo, 0, 64'd1);
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      if (freeze && starts > base) begin
        hit = 1'b1;
        break;
      end
    end
    check("hold_reached", 64'(hit), 64'd1);
    check("hold_starts", 64'(starts - base), 64'd6);
    reg_rd(SStat, d);
    check("hold_status", d, 64'h0000_0006_0000_0003);
    tick(20);
    check("hold_stays", 64'(starts - base), 64'd6);

    // Readback in HOLD
    fld_rd('h40, 2, en, fld, ix, d);
    check("rd_lo_en", 64'(en), 64'd1);
    check("rd_lo_idx", 64'(ix), 64'd2);
    check("rd_lo_data", d, 64'h0000_0000_1234_0002);
    fld_rd('h41, 2, en, fld, ix, d);
    check("rd_hi_data", d, 64'h0000_0000_C0DE_0002);
    fld_rd('h46, 2, en, fld, ix, d);
    check("rd_vx_field", 64'(fld), 64'd3);
    check("rd_vx_data", d, 64'h0000_0000_1234_0302);
    bus_wr(SRead, 0, 64'd1);
    check("read1_still_hold", 64'(freeze), 64'd1);
    bus_wr(SRead, 0, 64'd0);
    check("release_step_start", 64'(step_start), 64'd1);
    check("release_freeze", 64'(freeze), 64'd0);
    reg_rd(SStat, d);
    check("release_status", d, 64'h0000_0006_0000_0004);

    // Field accesses while running
    base = wr_pulses;
    bus_wr('h10, 1, 64'hAAAA);
    bus_wr('h11, 1, 64'hBBBB);
    tick(2);
    check("wait_no_commit", 64'(wr_pulses - base), 64'd0);
    reg_rd(SStat, d);
    check("wait_wr_err", d, 64'h0000_0006_0000_000C);
    fld_rd('h41, 0, en, fld, ix, d);
    check("wait_rd_dropped", 64'(en), 64'd0);
    check("wait_rd_keeps", d, 64'h0000_0006_0000_000C);
    reg_rd(SStat, d);
    check("wait_rd_err", d, 64'h0000_0006_0000_001C);
    bus_wr(SStat, 0, 64'd0);
    reg_rd(SStat, d);
    check("err_cleared", d, 64'h0000_0006_0000_0004);

    // Reset mid-step
    core_auto = 1'b0;
    base = starts;
    rst = 1'b0;
    #1;
    check("midrst_freeze", 64'(freeze), 64'd1);
    check("midrst_readdata", bif.readdata, 64'd0);
    check("midrst_step_start", 64'(step_start), 64'd0);
    tick(2);
    rst = 1'b1;
    tick(1);
    reg_rd(SStat, d);
    check("midrst_status", d, 64'd0);
    tick(150);
    check("midrst_no_start", 64'(starts - base), 64'd0);
    reg_rd(SStat, d);
    check("late_done_ignored", d, 64'd0);

    // GAP=0 acts as 1; GO=0 in HOLD keeps done
    bus_wr(SNb, 0, 64'd4);
    bus_wr(SGap, 0, 64'd0);
    bus_wr(SGo, 0, 64'd1);
    check("go_lat_1", 64'(step_start), 64'd0);
    tick(1);
    check("go_lat_2", 64'(step_start), 64'd1);
    tick(1);
    tb_done = 1'b1;
    tick(1);
    tb_done = 1'b0;
    check("gap0_hold", 64'(freeze), 64'd1);
    reg_rd(SStat, d);
    check("gap0_status", d, 64'h0000_0001_0000_0003);
    bus_wr(SGo, 0, 64'd0);
    reg_rd(SStat, d);
    check("hold_go0_status", d, 64'h0000_0001_0000_0001);

    // step_done in the same cycle GO=0 is written
    bus_wr(SGap, 0, 64'd100);
    bus_wr(SGo, 0, 64'd1);
    tick(1);
    check("restart", 64'(step_start), 64'd1);
    tick(1);
    base = starts;
    tb_done = 1'b1;
    bus_wr(SGo, 0, 64'd0);
    tb_done = 1'b0;
    check("go0_done_freeze", 64'(freeze), 64'd1);
    reg_rd(SStat, d);
    check("go0_done_status", d, 64'h0000_0002_0000_0001);
    tick(10);
    check("go0_no_start", 64'(starts - base), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
